// File: rtl/nibble_serial_add_ctrl.sv
// ============================================================================
//  Module      : nibble_serial_add_ctrl
//  Description : WIDTH-bit adder built from one shared 4-bit slice, one nibble
//                per clock (LSB first) with a valid/ready result handshake.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module four_bit_adder (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_cin,
    output logic [3:0] o_sum,
    output logic       o_cout
);
    assign {o_cout, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {4'b0000, i_cin};
endmodule

module nibble_serial_add_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin_in,
    output logic             busy,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] sum_out,
    output logic             cout_out
);
    localparam int NIB  = WIDTH / 4;
    localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;

    localparam logic [IDXW-1:0] c_IDX_LAST = IDXW'(NIB - 1);
    localparam logic [IDXW-1:0] c_IDX_ONE  = IDXW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_carry;
    logic [IDXW-1:0]  r_idx;
    logic [WIDTH-1:0] r_partial;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;

    logic [3:0]       w_nib_a;
    logic [3:0]       w_nib_b;
    logic [3:0]       w_nib_s;
    logic             w_c4;
    logic [WIDTH-1:0] w_partial_next;

    assign w_nib_a = r_a[{r_idx, 2'b00} +: 4];
    assign w_nib_b = r_b[{r_idx, 2'b00} +: 4];

    four_bit_adder u_slice (
        .i_a    (w_nib_a),
        .i_b    (w_nib_b),
        .i_cin  (r_carry),
        .o_sum  (w_nib_s),
        .o_cout (w_c4)
    );

    // Partial sum including the nibble being computed this cycle, so the last
    // nibble can be folded straight into sum_out on the final edge.
    always_comb begin
        w_partial_next = r_partial;
        w_partial_next[{r_idx, 2'b00} +: 4] = w_nib_s;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_a       <= '0;
            r_b       <= '0;
            r_carry   <= 1'b0;
            r_idx     <= '0;
            r_partial <= '0;
            r_sum     <= '0;
            r_cout    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_valid) begin
                        r_a       <= a_in;
                        r_b       <= b_in;
                        r_carry   <= cin_in;
                        r_idx     <= '0;
                        r_partial <= '0;
                        r_state   <= S_CALC;
                    end
                end
                S_CALC: begin
                    r_partial <= w_partial_next;
                    r_carry   <= w_c4;
                    if (r_idx == c_IDX_LAST) begin
                        r_sum   <= w_partial_next;
                        r_cout  <= w_c4;
                        r_idx   <= '0;
                        r_state <= S_DONE;
                    end else begin
                        r_idx <= r_idx + c_IDX_ONE;
                    end
                end
                S_DONE: begin
                    if (res_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign start_ready = (r_state == S_IDLE);
    assign busy        = (r_state != S_IDLE);
    assign res_valid   = (r_state == S_DONE);
    assign sum_out     = r_sum;
    assign cout_out    = r_cout;

endmodule

`default_nettype wire

// File: tb/tb_nibble_serial_add_ctrl.sv
// ============================================================================
//  Module      : tb_nibble_serial_add_ctrl
//  Description : Directed self-checking bench for nibble_serial_add_ctrl.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_nibble_serial_add_ctrl;
    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             start_valid;
    logic             start_ready;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             cin_in;
    logic             busy;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] sum_out;
    logic             cout_out;

    int n_checks = 0;
    int n_errors = 0;

    nibble_serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .a_in        (a_in),
        .b_in        (b_in),
        .cin_in      (cin_in),
        .busy        (busy),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .sum_out     (sum_out),
        .cout_out    (cout_out)
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present operands for one accepting edge; returns at the following negedge.
    task automatic start_add(input logic [15:0] a, input logic [15:0] b, input logic cin,
                             input string tag);
        @(negedge clk);
        start_valid = 1'b1;
        a_in        = a;
        b_in        = b;
        cin_in      = cin;
        @(posedge clk);
        #1;
        check_value({tag, "_busy"}, 32'(busy), 32'd1);
        check_value({tag, "_start_ready"}, 32'(start_ready), 32'd0);
        @(negedge clk);
        start_valid = 1'b0;
    endtask

    // Full add: accept, then count edges to res_valid while disturbing inputs.
    task automatic do_add(input logic [15:0] a, input logic [15:0] b, input logic cin,
                          input logic [15:0] exp_sum, input logic exp_cout, input string tag);
        int n;
        start_add(a, b, cin, tag);
        n = 1;
        @(posedge clk);
        #1;
        a_in        = 16'hDEAD;
        b_in        = 16'hBEEF;
        cin_in      = 1'b1;
        start_valid = 1'b1;
        while (!res_valid && n < 20) begin
            @(posedge clk);
            #1;
            start_valid = 1'b0;
            n++;
        end
        start_valid = 1'b0;
        check_value({tag, "_latency"}, 32'(n), 32'd4);
        check_value({tag, "_sum"}, 32'(sum_out), 32'(exp_sum));
        check_value({tag, "_cout"}, 32'(cout_out), 32'(exp_cout));
    endtask

    // With res_ready high, DONE lasts one cycle and the result stays visible in IDLE.
    task automatic expect_idle_hold(input logic [15:0] exp_sum, input logic exp_cout, input string tag);
        @(posedge clk);
        #1;
        check_value({tag, "_idle_valid"}, 32'(res_valid), 32'd0);
        check_value({tag, "_idle_ready"}, 32'(start_ready), 32'd1);
        check_value({tag, "_idle_busy"}, 32'(busy), 32'd0);
        check_value({tag, "_idle_sum"}, {15'd0, cout_out, sum_out}, {15'd0, exp_cout, exp_sum});
    endtask

    initial begin
        int stray_valid;
        rst         = 1'b1;
        start_valid = 1'b0;
        a_in        = '0;
        b_in        = '0;
        cin_in      = 1'b0;
        res_ready   = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        check_value("rst_busy", 32'(busy), 32'd0);
        check_value("rst_valid", 32'(res_valid), 32'd0);
        check_value("rst_sum", {15'd0, cout_out, sum_out}, 32'd0);
        check_value("rst_start_ready", 32'(start_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;

        do_add(16'h0003, 16'h0003, 1'b0, 16'h0006, 1'b0, "t1");
        expect_idle_hold(16'h0006, 1'b0, "t1");
        do_add(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, "t2");
        expect_idle_hold(16'h0000, 1'b1, "t2");
        do_add(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, "t3");
        expect_idle_hold(16'hFFFF, 1'b1, "t3");

        // Abort while the slice is on nibble 2.
        start_add(16'h1234, 16'h1111, 1'b0, "t5");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_value("t5_busy", 32'(busy), 32'd0);
        check_value("t5_valid", 32'(res_valid), 32'd0);
        check_value("t5_sum", 32'(sum_out), 32'd0);
        check_value("t5_cout", 32'(cout_out), 32'd0);
        check_value("t5_start_ready", 32'(start_ready), 32'd1);
        stray_valid = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (res_valid || busy) stray_valid++;
        end
        check_value("t5_no_result", 32'(stray_valid), 32'd0);

        // Back-pressured result with a start pulse that must be ignored.
        res_ready = 1'b0;
        do_add(16'h00F0, 16'h0F10, 1'b1, 16'h1001, 1'b0, "t4");
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            if (k == 2) begin
                start_valid = 1'b1;
                a_in        = 16'h1111;
                b_in        = 16'h2222;
                cin_in      = 1'b0;
            end else begin
                start_valid = 1'b0;
            end
            check_value($sformatf("t4_hold_valid_%0d", k), 32'(res_valid), 32'd1);
            check_value($sformatf("t4_hold_ready_%0d", k), 32'(start_ready), 32'd0);
            check_value($sformatf("t4_hold_sum_%0d", k), 32'(sum_out), 32'h1001);
        end
        res_ready = 1'b1;
        expect_idle_hold(16'h1001, 1'b0, "t4");

        do_add(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, "t6a");
        expect_idle_hold(16'h5555, 1'b0, "t6a");
        do_add(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, "t6b");
        expect_idle_hold(16'h0000, 1'b1, "t6b");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
